ntt_bf_ctrl: RTL and testbench

Sequencing controller for one butterfly unit (BFU) in the NTT accelerator.
- On `start`, walks all log2(N) stages of an in-place forward NTT (Cooley-Tukey, BFU op=0) or inverse NTT (Gentleman-Sande, BFU op=1).
- Each cycle it issues one butterfly's coefficient-memory read addresses and twiddle-ROM address.
- It holds the BFU `op` select and generates write-back addresses latency-matched to the memory-plus-BFU pipeline.
- It sits between the top-level command interface and the coefficient RAM / twiddle ROM / BFU datapath.
- INTT N^-1 scaling and bit-reversal are out of scope.

---
 rtl/ntt_bf_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_ntt_bf_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ntt_bf_ctrl.sv
// Butterfly sequencing controller: walks every NTT/INTT stage, issuing one
// butterfly read per cycle and replaying its addresses as writes after the pipeline.
module ntt_bf_ctrl #(
    parameter int LOGN    = 8,
    parameter int RD_LAT  = 1,
    parameter int BFU_LAT = 8
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            mode,
    output logic            busy,
    output logic            done,
    output logic            bfu_op,
    output logic            rd_en,
    output logic [LOGN-1:0] rd_addr_a,
    output logic [LOGN-1:0] rd_addr_b,
    output logic [LOGN-1:0] tw_addr,
    output logic            wr_en,
    output logic [LOGN-1:0] wr_addr_a,
    output logic [LOGN-1:0] wr_addr_b
);

    localparam int L  = RD_LAT + BFU_LAT;
    localparam int BW = LOGN - 1;
    localparam int SW = (LOGN > 1) ? $clog2(LOGN) : 1;
    localparam int DW = (L > 1) ? $clog2(L) : 1;

    localparam logic [BW-1:0] B_LAST = '1;
    localparam logic [SW-1:0] S_LAST = SW'(LOGN - 1);
    localparam logic [DW-1:0] D_LAST = DW'(L - 1);
    localparam logic [LOGN:0] N_FULL = {1'b1, {LOGN{1'b0}}};
    localparam logic [LOGN:0] ONE_W  = {{LOGN{1'b0}}, 1'b1};

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_DRAIN, ST_DONE} state_t;

    state_t        state_reg, state_next;
    logic [BW-1:0] b_reg, b_next;
    logic [SW-1:0] s_reg, s_next;
    logic [DW-1:0] d_reg, d_next;
    logic          op_reg, op_next;

    logic            busy_reg, busy_next;
    logic            done_reg, done_next;
    logic            rd_en_reg, rd_en_next;
    logic [LOGN-1:0] rd_a_reg, rd_a_next;
    logic [LOGN-1:0] rd_b_reg, rd_b_next;
    logic [LOGN-1:0] tw_reg, tw_next;

    logic            dly_en [L];
    logic [LOGN-1:0] dly_a  [L];
    logic [LOGN-1:0] dly_b  [L];

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_reg <= ST_IDLE;
            b_reg     <= '0;
            s_reg     <= '0;
            d_reg     <= '0;
            op_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            b_reg     <= b_next;
            s_reg     <= s_next;
            d_reg     <= d_next;
            op_reg    <= op_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state_reg;
        b_next     = b_reg;
        s_next     = s_reg;
        d_next     = d_reg;
        op_next    = op_reg;
        unique case (state_reg)
            ST_IDLE: begin
                if (start) begin
                    state_next = ST_ISSUE;
                    op_next    = mode;
                    b_next     = '0;
                    s_next     = '0;
                    d_next     = '0;
                end
            end
            ST_ISSUE: begin
                if (b_reg == B_LAST) begin
                    state_next = ST_DRAIN;
                    d_next     = '0;
                end else begin
                    b_next = b_reg + 1'b1;
                end
            end
            ST_DRAIN: begin
                if (d_reg == D_LAST) begin
                    b_next = '0;
                    if (s_reg == S_LAST) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_ISSUE;
                        s_next     = s_reg + 1'b1;
                    end
                end else begin
                    d_next = d_reg + 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Output logic: computed from the next state so every output is a flop
    logic [SW-1:0]   m;
    logic [LOGN-1:0] b_ext, len, g, j, a;
    logic [LOGN:0]   tw_wide;

    always_comb begin
        m          = op_next ? s_next : (S_LAST - s_next);
        b_ext      = {1'b0, b_next};
        len        = LOGN'(1) << m;
        g          = b_ext >> m;
        j          = b_ext & (len - LOGN'(1));
        a          = ((g << m) << 1) | j;
        tw_wide    = op_next ? ((N_FULL >> m) - ONE_W - {1'b0, g})
                             : (((N_FULL >> m) >> 1) + {1'b0, g});
        rd_en_next = (state_next == ST_ISSUE);
        busy_next  = (state_next == ST_ISSUE) || (state_next == ST_DRAIN);
        done_next  = (state_next == ST_DONE);
        rd_a_next  = '0;
        rd_b_next  = '0;
        tw_next    = '0;
        if (rd_en_next) begin
            rd_a_next = a;
            rd_b_next = a + len;
            tw_next   = tw_wide[LOGN-1:0];
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            rd_en_reg <= 1'b0;
            rd_a_reg  <= '0;
            rd_b_reg  <= '0;
            tw_reg    <= '0;
        end else begin
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            rd_en_reg <= rd_en_next;
            rd_a_reg  <= rd_a_next;
            rd_b_reg  <= rd_b_next;
            tw_reg    <= tw_next;
        end
    end

    // Write-back delay line; reset flushes pending writes
    generate
        for (genvar gi = 0; gi < L; gi++) begin : g_dly
            always_ff @(posedge clk or negedge rstn) begin
                if (!rstn) begin
                    dly_en[gi] <= 1'b0;
                    dly_a[gi]  <= '0;
                    dly_b[gi]  <= '0;
                end else if (gi == 0) begin
                    dly_en[gi] <= rd_en_reg;
                    dly_a[gi]  <= rd_a_reg;
                    dly_b[gi]  <= rd_b_reg;
                end else begin
                    dly_en[gi] <= dly_en[(gi > 0) ? gi - 1 : 0];
                    dly_a[gi]  <= dly_a[(gi > 0) ? gi - 1 : 0];
                    dly_b[gi]  <= dly_b[(gi > 0) ? gi - 1 : 0];
                end
            end
        end
    endgenerate

    assign busy      = busy_reg;
    assign done      = done_reg;
    assign bfu_op    = op_reg;
    assign rd_en     = rd_en_reg;
    assign rd_addr_a = rd_a_reg;
    assign rd_addr_b = rd_b_reg;
    assign tw_addr   = tw_reg;
    assign wr_en     = dly_en[L-1];
    assign wr_addr_a = dly_a[L-1];
    assign wr_addr_b = dly_b[L-1];

endmodule

// File: tb/tb_ntt_bf_ctrl.sv
// Bench for ntt_bf_ctrl: an N=8 and an N=256 instance checked cycle by cycle
// against a stage/block/offset model of the transform schedule.
module tb_ntt_bf_ctrl;

    localparam int LAT  = 9;
    localparam int MAXC = 1110;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic st = 1'b0;
    logic mode = 1'b0;
    logic sel = 1'b0;
    logic start3, start8;

    always #5 clk = ~clk;

    assign start3 = st & ~sel;
    assign start8 = st & sel;

    logic       busy3, done3, op3, rd3, wr3;
    logic [2:0] a3, b3, tw3, wa3, wb3;
    logic       busy8, done8, op8, rd8, wr8;
    logic [7:0] a8, b8, tw8, wa8, wb8;

    ntt_bf_ctrl #(.LOGN(3), .RD_LAT(1), .BFU_LAT(8)) dut3 (
        .clk(clk), .rstn(rstn), .start(start3), .mode(mode),
        .busy(busy3), .done(done3), .bfu_op(op3), .rd_en(rd3),
        .rd_addr_a(a3), .rd_addr_b(b3), .tw_addr(tw3),
        .wr_en(wr3), .wr_addr_a(wa3), .wr_addr_b(wb3)
    );

    ntt_bf_ctrl #(.LOGN(8), .RD_LAT(1), .BFU_LAT(8)) dut8 (
        .clk(clk), .rstn(rstn), .start(start8), .mode(mode),
        .busy(busy8), .done(done8), .bfu_op(op8), .rd_en(rd8),
        .rd_addr_a(a8), .rd_addr_b(b8), .tw_addr(tw8),
        .wr_en(wr8), .wr_addr_a(wa8), .wr_addr_b(wb8)
    );

    logic       o_busy, o_done, o_op, o_rd, o_wr;
    logic [7:0] o_a, o_b, o_tw, o_wa, o_wb;

    always_comb begin
        if (sel) begin
            {o_busy, o_done, o_op, o_rd, o_wr} = {busy8, done8, op8, rd8, wr8};
            {o_a, o_b, o_tw, o_wa, o_wb}       = {a8, b8, tw8, wa8, wb8};
        end else begin
            {o_busy, o_done, o_op, o_rd, o_wr} = {busy3, done3, op3, rd3, wr3};
            o_a  = {5'b0, a3};
            o_b  = {5'b0, b3};
            o_tw = {5'b0, tw3};
            o_wa = {5'b0, wa3};
            o_wb = {5'b0, wb3};
        end
    end

    bit e_rd [MAXC];
    bit e_wr [MAXC];
    int e_a  [MAXC];
    int e_b  [MAXC];
    int e_tw [MAXC];
    int e_wa [MAXC];
    int e_wb [MAXC];

    int total = 0;
    int bad = 0;
    int cnt_rd, cnt_wr, done_cyc, tw_prev, tw_first, tw_distinct;
    bit tw_mono;

    // Schedule model: stages in transform order, butterflies grouped by block,
    // each stage followed by a pipeline drain. Returns the done cycle.
    function automatic int build(input int logn, input bit md);
        int n, len, m, cyc, blk, a;
        n = 1 << logn;
        for (int c = 0; c < MAXC; c++) begin
            e_rd[c] = 0; e_wr[c] = 0;
            e_a[c] = 0; e_b[c] = 0; e_tw[c] = 0; e_wa[c] = 0; e_wb[c] = 0;
        end
        cyc = 1;
        for (int s = 0; s < logn; s++) begin
            m   = md ? s : logn - 1 - s;
            len = 1 << m;
            blk = 0;
            for (int base = 0; base < n; base += 2 * len) begin
                for (int jj = 0; jj < len; jj++) begin
                    a = base + jj;
                    e_rd[cyc] = 1;
                    e_a[cyc]  = a;
                    e_b[cyc]  = a + len;
                    e_tw[cyc] = md ? (n / len - 1 - blk) : (n / (2 * len) + blk);
                    e_wr[cyc + LAT] = 1;
                    e_wa[cyc + LAT] = a;
                    e_wb[cyc + LAT] = a + len;
                    cyc++;
                end
                blk++;
            end
            cyc += LAT;
        end
        return cyc;
    endfunction

    // One transform; ign >= 1 pulses start with the other mode during that cycle
    task automatic run(input bit s8, input bit md, input int ign);
        int t;
        t = build(s8 ? 8 : 3, md);
        sel = s8;
        cnt_rd = 0; cnt_wr = 0; done_cyc = -1;
        tw_prev = 0; tw_first = -1; tw_distinct = 0; tw_mono = 1;
        @(negedge clk);
        mode = md;
        st = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= t + 3; k++) begin
            @(negedge clk);
            if (k == 1) st = 1'b0;
            total++;
            if (o_busy !== (k < t)) begin
                bad++; $display("FAIL busy cyc=%0d got=%b exp=%b", k, o_busy, (k < t));
            end
            total++;
            if (o_done !== (k == t)) begin
                bad++; $display("FAIL done cyc=%0d got=%b exp=%b", k, o_done, (k == t));
            end
            total++;
            if (o_op !== md) begin
                bad++; $display("FAIL bfu_op cyc=%0d got=%b exp=%b", k, o_op, md);
            end
            total++;
            if (o_rd !== e_rd[k]) begin
                bad++; $display("FAIL rd_en cyc=%0d got=%b exp=%b", k, o_rd, e_rd[k]);
            end
            if (e_rd[k]) begin
                total++;
                if (o_a !== 8'(e_a[k]) || o_b !== 8'(e_b[k]) || o_tw !== 8'(e_tw[k])) begin
                    bad++;
                    $display("FAIL rd_addr cyc=%0d got=(%0d,%0d,%0d) exp=(%0d,%0d,%0d)",
                             k, o_a, o_b, o_tw, e_a[k], e_b[k], e_tw[k]);
                end
            end
            total++;
            if (o_wr !== e_wr[k]) begin
                bad++; $display("FAIL wr_en cyc=%0d got=%b exp=%b", k, o_wr, e_wr[k]);
            end
            if (e_wr[k]) begin
                total++;
                if (o_wa !== 8'(e_wa[k]) || o_wb !== 8'(e_wb[k])) begin
                    bad++;
                    $display("FAIL wr_addr cyc=%0d got=(%0d,%0d) exp=(%0d,%0d)",
                             k, o_wa, o_wb, e_wa[k], e_wb[k]);
                end
            end
            if (o_done === 1'b1) done_cyc = k;
            if (o_wr === 1'b1) cnt_wr++;
            if (o_rd === 1'b1) begin
                if (cnt_rd == 0) tw_first = int'(o_tw);
                else if (int'(o_tw) < tw_prev) tw_mono = 0;
                if (cnt_rd == 0 || int'(o_tw) != tw_prev) tw_distinct++;
                tw_prev = int'(o_tw);
                cnt_rd++;
            end
            if (k == ign) begin
                st = 1'b1;
                mode = ~md;
            end
            if (k == ign + 1) begin
                st = 1'b0;
                mode = md;
            end
        end
        st = 1'b0;
        $display("run logn=%0d mode=%0d ign=%0d done_at=%0d reads=%0d writes=%0d",
                 s8 ? 8 : 3, md, ign, done_cyc, cnt_rd, cnt_wr);
    endtask

    task automatic test_reset;
        rstn = 1'b0;
        #1;
        total++;
        if ({busy3, done3, op3, rd3, wr3, a3, b3, tw3, wa3, wb3} !== '0) begin
            bad++; $display("FAIL reset3 got=%h exp=0", {busy3, done3, op3, rd3, wr3, a3, b3, tw3, wa3, wb3});
        end
        total++;
        if ({busy8, done8, op8, rd8, wr8, a8, b8, tw8, wa8, wb8} !== '0) begin
            bad++; $display("FAIL reset8 got=%h exp=0", {busy8, done8, op8, rd8, wr8, a8, b8, tw8, wa8, wb8});
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        $display("reset released");
    endtask

    task automatic test_ntt;
        run(1'b0, 1'b0, -1);
        total++;
        if (done_cyc !== 40) begin
            bad++; $display("FAIL ntt_done_cycle got=%0d exp=40", done_cyc);
        end
    endtask

    task automatic test_intt;
        run(1'b0, 1'b1, -1);
        total++;
        if (done_cyc !== 40) begin
            bad++; $display("FAIL intt_done_cycle got=%0d exp=40", done_cyc);
        end
    endtask

    task automatic test_ignored_start;
        run(1'b0, 1'b0, 5);
        run(1'b0, 1'b1, 40);
    endtask

    task automatic test_reset_mid;
        sel = 1'b0;
        @(negedge clk);
        mode = 1'b0;
        st = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            st = 1'b0;
        end
        total++;
        if (wr3 !== 1'b1) begin
            bad++; $display("FAIL mid_wr_pending got=%b exp=1", wr3);
        end
        rstn = 1'b0;
        #1;
        total++;
        if ({busy3, done3, op3, rd3, wr3, a3, b3, tw3, wa3, wb3} !== '0) begin
            bad++; $display("FAIL mid_reset got=%h exp=0", {busy3, done3, op3, rd3, wr3, a3, b3, tw3, wa3, wb3});
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            total++;
            if (wr3 !== 1'b0 || rd3 !== 1'b0 || busy3 !== 1'b0) begin
                bad++; $display("FAIL post_reset cyc=%0d got wr=%b rd=%b busy=%b exp=0", k, wr3, rd3, busy3);
            end
        end
        $display("mid-transform reset checked");
        run(1'b0, 1'($urandom_range(0, 1)), -1);
    endtask

    task automatic test_random;
        bit md;
        int ign;
        for (int r = 0; r < 6; r++) begin
            md  = 1'($urandom_range(0, 1));
            ign = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(1, 40));
            repeat ($urandom_range(0, 4)) @(negedge clk);
            run(1'b0, md, ign);
        end
    endtask

    task automatic test_large;
        run(1'b1, 1'b0, -1);
        total++;
        if (cnt_rd !== 1024) begin
            bad++; $display("FAIL large_rd_count got=%0d exp=1024", cnt_rd);
        end
        total++;
        if (cnt_wr !== 1024) begin
            bad++; $display("FAIL large_wr_count got=%0d exp=1024", cnt_wr);
        end
        total++;
        if (done_cyc !== 1097) begin
            bad++; $display("FAIL large_done_cycle got=%0d exp=1097", done_cyc);
        end
        total++;
        if (tw_first !== 1 || tw_prev !== 255 || tw_distinct !== 255 || tw_mono !== 1'b1) begin
            bad++;
            $display("FAIL large_tw_order got first=%0d last=%0d distinct=%0d mono=%0d exp 1,255,255,1",
                     tw_first, tw_prev, tw_distinct, tw_mono);
        end
    endtask

    initial begin
        test_reset;
        test_ntt;
        test_intt;
        test_ignored_start;
        test_reset_mid;
        test_random;
        test_large;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
